polar_sc_decoder_seq: RTL and testbench

- Sequential successive-cancellation (SC) polar decoder. It is the clocked, frame-based successor to the fully combinational recursive decoder.
- It accepts one frame of N channel LLRs plus a per-frame frozen-bit mask over a valid/ready handshake.
- It walks the SC tree depth-first using one shared node datapath with saturating min-sum arithmetic.
- It returns N hard decisions over a valid/ready handshake. It sits between the LLR demapper and the frame sink.

---
 rtl/polar_sc_decoder_seq.sv | 178 +++++++++++++++++
 tb/tb_polar_sc_decoder_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/polar_sc_decoder_seq.sv
// Sequential successive-cancellation polar decoder: one shared F/G/leaf/combine
// datapath walks the decoding tree depth-first, one node operation per cycle.
module polar_sc_decoder_seq #(
   parameter int N     = 8,
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] llr_in,
   input  logic [N-1:0]       frozen_mask,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N-1:0]       u_out,
   output logic               busy
);
   localparam int LOG = $clog2(N);
   localparam int DW  = $clog2(LOG + 1);
   localparam int NL  = 1 << DW;
   localparam int H   = N / 2;
   localparam logic [DW-1:0]    DEP_LEAF = DW'(LOG);
   localparam logic [DW-1:0]    DEP_ONE  = DW'(1);
   localparam logic [LOG-1:0]   IDX_ONE  = LOG'(1);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] MAXV     = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MINV     = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MNEG     = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_F = 3'd1, S_G = 3'd2, S_LEAF = 3'd3, S_COMB = 3'd4, S_DONE = 3'd5
   } state_t;

   // Most negative code has no positive twin; fold it so |x| always fits.
   function automatic logic [WIDTH-1:0] f_clamp(input logic [WIDTH-1:0] x);
      return (x == MNEG) ? MINV : x;
   endfunction

   function automatic logic [WIDTH-1:0] f_min(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] ma, mb, m;
      ma = a[WIDTH-1] ? (~a + ONE) : a;
      mb = b[WIDTH-1] ? (~b + ONE) : b;
      m  = (ma < mb) ? ma : mb;
      return (a[WIDTH-1] ^ b[WIDTH-1]) ? (~m + ONE) : m;
   endfunction

   function automatic logic [WIDTH-1:0] f_g(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic k);
      logic [WIDTH:0] s;
      s = k ? ({b[WIDTH-1], b} - {a[WIDTH-1], a}) : ({b[WIDTH-1], b} + {a[WIDTH-1], a});
      if (!s[WIDTH] && s[WIDTH-1]) begin
         return MAXV;
      end else if (s[WIDTH] && !(s[WIDTH-1] && (|s[WIDTH-2:0]))) begin
         return MINV;
      end else begin
         return s[WIDTH-1:0];
      end
   endfunction

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_llr [NL][N];
   logic [N-1:0]     r_bu [NL];
   logic [N-1:0]     r_bl [NL];
   logic [N-1:0]     r_mask, r_u;
   logic [DW-1:0]    r_dep, w_dep_dn, w_dep_up;
   logic [LOG-1:0]   r_idx;
   logic             r_in_ready, r_out_valid, r_busy;
   logic [WIDTH-1:0] w_node [N];
   logic [WIDTH-1:0] w_f [H];
   logic [WIDTH-1:0] w_g [H];
   logic [N-1:0]     w_beta;
   logic             w_dec;

   // Node datapath: F, G, leaf decision and partial-sum combine for the current node
   always_comb begin
      w_dep_dn = r_dep + DEP_ONE;
      w_dep_up = r_dep - DEP_ONE;
      w_node   = r_llr[r_dep];
      w_beta   = '0;
      for (int i = 0; i < H; i++) begin
         w_f[i]        = f_min(w_node[2*i], w_node[2*i+1]);
         w_g[i]        = f_g(w_node[2*i], w_node[2*i+1], r_bu[w_dep_dn][i]);
         w_beta[2*i]   = r_bu[w_dep_dn][i] ^ r_bl[w_dep_dn][i];
         w_beta[2*i+1] = r_bl[w_dep_dn][i];
      end
      w_dec = ~r_mask[r_idx] & w_node[0][WIDTH-1];
   end

   // Tree walk: descend on F/G, return to parent G (upper child) or COMB (lower child)
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (in_valid) w_state_nxt = S_F; else w_state_nxt = S_IDLE;
         S_F, S_G: if (w_dep_dn == DEP_LEAF) w_state_nxt = S_LEAF; else w_state_nxt = S_F;
         S_LEAF: if (r_idx[0]) w_state_nxt = S_COMB; else w_state_nxt = S_G;
         S_COMB: begin
            if (r_dep == '0) w_state_nxt = S_DONE;
            else if (r_idx[0]) w_state_nxt = S_COMB;
            else w_state_nxt = S_G;
         end
         S_DONE: if (out_ready) w_state_nxt = S_IDLE; else w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register and registered handshake/status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt == S_IDLE);
         r_out_valid <= (w_state_nxt == S_DONE);
         r_busy      <= (w_state_nxt != S_IDLE);
      end
   end

   // Frame capture, level LLR buffers, partial sums and decisions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < NL; d++) begin
            r_bu[d] <= '0;
            r_bl[d] <= '0;
            for (int i = 0; i < N; i++) r_llr[d][i] <= '0;
         end
         r_mask <= '0;
         r_u    <= '0;
         r_dep  <= '0;
         r_idx  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < N; i++) r_llr[0][i] <= f_clamp(llr_in[i*WIDTH +: WIDTH]);
                  r_mask <= frozen_mask;
                  r_u    <= '0;
                  r_dep  <= '0;
                  r_idx  <= '0;
               end
            end
            S_F: begin
               for (int i = 0; i < H; i++) r_llr[w_dep_dn][i] <= w_f[i];
               r_dep <= w_dep_dn;
               r_idx <= r_idx << 1'b1;
            end
            S_G: begin
               for (int i = 0; i < H; i++) r_llr[w_dep_dn][i] <= w_g[i];
               r_dep <= w_dep_dn;
               r_idx <= (r_idx << 1'b1) | IDX_ONE;
            end
            S_LEAF: begin
               r_u[r_idx] <= w_dec;
               if (r_idx[0]) r_bl[r_dep][0] <= w_dec;
               else r_bu[r_dep][0] <= w_dec;
               r_dep <= w_dep_up;
               r_idx <= r_idx >> 1'b1;
            end
            S_COMB: begin
               if (r_dep != '0) begin
                  if (r_idx[0]) r_bl[r_dep] <= w_beta;
                  else r_bu[r_dep] <= w_beta;
                  r_dep <= w_dep_up;
                  r_idx <= r_idx >> 1'b1;
               end
            end
            default: r_dep <= r_dep;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign u_out     = r_u;
endmodule

// File: tb/tb_polar_sc_decoder_seq.sv
// Self-checking bench for polar_sc_decoder_seq (N=8, WIDTH=8) with an
// independent leaf-by-leaf SC min-sum model feeding a scoreboard queue.
module tb_polar_sc_decoder_seq;
   localparam int N    = 8;
   localparam int W    = 8;
   localparam int LOG  = 3;
   localparam int MAXI = 127;
   localparam int LAT  = 4*N - 3;

   logic           clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic           in_ready, out_valid, busy;
   logic [N*W-1:0] llr_in = '0;
   logic [N-1:0]   frozen_mask = '0;
   logic [N-1:0]   u_out;
   int             checks = 0, errors = 0, cyc = 0;

   typedef struct {logic [N-1:0] u; logic [N-1:0] m; int acc;} exp_t;
   exp_t q_exp[$];

   polar_sc_decoder_seq #(.N(N), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .llr_in(llr_in), .frozen_mask(frozen_mask), .out_valid(out_valid),
      .out_ready(out_ready), .u_out(u_out), .busy(busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int sat(input int x);
      if (x > MAXI) return MAXI;
      else if (x < -MAXI) return -MAXI;
      else return x;
   endfunction

   function automatic int fmin(input int a, input int b);
      int ma, mb, m;
      ma = (a < 0) ? -a : a;
      mb = (b < 0) ? -b : b;
      m  = (ma < mb) ? ma : mb;
      return ((a < 0) != (b < 0)) ? -m : m;
   endfunction

   // Decode each leaf from the root, re-encoding already decided upper-sibling bits.
   function automatic logic [N-1:0] model(input logic [N*W-1:0] l, input logic [N-1:0] m);
      int ch[N]; int v[N]; int nv[N];
      int hs, b, p, base;
      logic [N-1:0] u, cur, nxt;
      u = '0;
      for (int i = 0; i < N; i++) begin
         ch[i] = $signed(l[i*W +: W]);
         if (ch[i] < -MAXI) ch[i] = -MAXI;
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) v[j] = ch[j];
         for (int d = 0; d < LOG; d++) begin
            hs = (N >> d) / 2;
            b  = (i >> (LOG-1-d)) & 1;
            p  = i >> (LOG-d);
            for (int j = 0; j < N; j++) nv[j] = 0;
            if (b == 1) begin
               base = (2*p) << (LOG-d-1);
               cur = '0;
               for (int j = 0; j < hs; j++) cur[j] = u[base+j];
               for (int s = 1; s < hs; s = s*2) begin
                  nxt = '0;
                  for (int t = 0; t < hs/(2*s); t++)
                     for (int k = 0; k < s; k++) begin
                        nxt[t*2*s+2*k]   = cur[2*t*s+k] ^ cur[(2*t+1)*s+k];
                        nxt[t*2*s+2*k+1] = cur[(2*t+1)*s+k];
                     end
                  cur = nxt;
               end
               for (int j = 0; j < hs; j++) nv[j] = sat(v[2*j+1] + (cur[j] ? -v[2*j] : v[2*j]));
            end else begin
               for (int j = 0; j < hs; j++) nv[j] = fmin(v[2*j], v[2*j+1]);
            end
            for (int j = 0; j < N; j++) v[j] = nv[j];
         end
         u[i] = m[i] ? 1'b0 : (v[0] < 0);
      end
      return u;
   endfunction

   task automatic drive_frame(input logic [N*W-1:0] l, input logic [N-1:0] m);
      int n;
      exp_t e;
      n = 0;
      while (in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL drive_timeout in_ready=%b required 1", in_ready);
      end else begin
         llr_in = l; frozen_mask = m; in_valid = 1'b1;
         @(posedge clk); @(negedge clk);
         in_valid = 1'b0;
         llr_in = {$urandom, $urandom};
         frozen_mask = N'($urandom);
         e.u = model(l, m); e.m = m; e.acc = cyc;
         q_exp.push_back(e);
         if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept busy=%b in_ready=%b required 1/0", busy, in_ready);
         end
      end
   endtask

   task automatic collect();
      int n;
      exp_t e;
      out_ready = 1'b1;
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      if (q_exp.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_empty out_valid=%b", out_valid);
      end else begin
         e = q_exp.pop_front();
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_timeout out_valid=%b required 1", out_valid);
         end else begin
            if (u_out !== e.u) begin
               errors++;
               $display("FAIL u_out got=%b required=%b", u_out, e.u);
            end
            checks++;
            if (cyc - e.acc !== LAT) begin
               errors++;
               $display("FAIL latency got=%0d required=%0d", cyc - e.acc, LAT);
            end
            checks++;
            if ((u_out & e.m) !== '0) begin
               errors++;
               $display("FAIL frozen u_out=%b mask=%b", u_out, e.m);
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
               errors++;
               $display("FAIL post_handshake out_valid=%b in_ready=%b busy=%b required 0/1/0",
                        out_valid, in_ready, busy);
            end
         end
      end
   endtask

   function automatic logic [N*W-1:0] fill(input int a, input int b);
      logic [N*W-1:0] l;
      for (int i = 0; i < N; i++) l[i*W +: W] = (i % 2 == 0) ? W'(a) : W'(b);
      return l;
   endfunction

   task automatic test_reset();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || u_out !== '0) begin
         errors++;
         $display("FAIL reset in_ready=%b out_valid=%b busy=%b u_out=%b required 1/0/0/0",
                  in_ready, out_valid, busy, u_out);
      end
   endtask

   task automatic test_directed();
      drive_frame(fill(127, 127), 8'h00);   collect();  // g saturation
      drive_frame(fill(-1, -1), 8'h00);     collect();
      drive_frame(fill(-128, -128), 8'h55); collect();  // capture clamp
      drive_frame(fill(0, 0), 8'h00);       collect();  // zero decides 0
      drive_frame(fill(20, -30), 8'h0F);    collect();
      drive_frame(fill(-100, -100), 8'hFF); collect();
      drive_frame(fill(-5, 3), 8'h00);      collect();
      drive_frame(fill(-5, 3), 8'h01);      collect();
   endtask

   task automatic test_back_to_back();
      logic [N*W-1:0] l;
      for (int f = 0; f < 300; f++) begin
         for (int i = 0; i < N; i++)
            l[i*W +: W] = (f % 2 == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 40) - 20);
         drive_frame(l, N'($urandom_range(0, 255)));
         collect();
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int n;
      logic [N*W-1:0] lb;
      drive_frame(fill(-40, 17), 8'h11);
      out_ready = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      e = q_exp.pop_front();
      checks++;
      if (out_valid !== 1'b1 || u_out !== e.u || cyc - e.acc !== LAT) begin
         errors++;
         $display("FAIL bp_first out_valid=%b u_out=%b lat=%0d required 1/%b/%0d",
                  out_valid, u_out, cyc - e.acc, e.u, LAT);
      end
      lb = fill(-9, -60);
      llr_in = lb; frozen_mask = 8'h80; in_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || u_out !== e.u || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold c=%0d out_valid=%b u_out=%b in_ready=%b required 1/%b/0",
                     c, out_valid, u_out, in_ready, e.u);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      e.u = model(lb, 8'h80); e.m = 8'h80; e.acc = cyc;
      q_exp.push_back(e);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_second_accept busy=%b in_ready=%b required 1/0", busy, in_ready);
      end
      collect();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      drive_frame(fill(-70, -70), 8'h00);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      e = q_exp.pop_front();
      checks++;
      if (out_valid !== 1'b0 || u_out !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid out_valid=%b u_out=%b in_ready=%b busy=%b required 0/0/1/0",
                  out_valid, u_out, in_ready, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drive_frame(fill(33, -90), 8'h24);
      collect();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
